// File: rtl/ix_pkg.sv
// rtl/ix_pkg.sv - shared opcodes, FSM encoding and width default for the IX mul/div unit
package ix_pkg;

  localparam int IX_XLEN = 32;

  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;
  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } ix_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - combinational conditional two's-complement negation
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/ix_muldiv_unit.sv
// rtl/ix_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO unit with HI/LO registers
// Optional MULDIV_EARLY_TERM_EN stops multiplication once the remaining multiplier is zero.
module ix_muldiv_unit
  import ix_pkg::*;
#(
  parameter int XLEN  = IX_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      alu_op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  ix_state_e         state_q;
  logic              busy_q, done_q, dbz_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [CNT_W-1:0]  cnt_q;
  // Product for MUL; {remainder, quotient/dividend} for DIV.
  logic [2*XLEN-1:0] prod_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_res_q, neg_rem_q, is_div_q;

  logic              is_signed;
  logic [XLEN-1:0]   abs_a, abs_b, fix_rem;
  logic [2*XLEN-1:0] fix_prod, mul_sum;
  logic [XLEN-1:0]   mplier_nxt;
  logic [XLEN:0]     div_shift, div_diff;
  logic              last_iter;

  assign is_signed = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);

  muldiv_negate #(.W(XLEN)) u_abs_a (
    .neg_i(is_signed & A[XLEN-1]), .val_i(A), .val_o(abs_a));
  muldiv_negate #(.W(XLEN)) u_abs_b (
    .neg_i(is_signed & B[XLEN-1]), .val_i(B), .val_o(abs_b));
  // Low half of a 2*XLEN negation equals the XLEN negation, so this also fixes the quotient.
  muldiv_negate #(.W(2*XLEN)) u_fix_prod (
    .neg_i(neg_res_q), .val_i(prod_q), .val_o(fix_prod));
  muldiv_negate #(.W(XLEN)) u_fix_rem (
    .neg_i(neg_rem_q), .val_i(prod_q[2*XLEN-1:XLEN]), .val_o(fix_rem));

  assign mul_sum    = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_nxt = mplier_q >> 1;
  assign div_shift  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign div_diff   = div_shift - {1'b0, mcand_q[XLEN-1:0]};
  assign last_iter  = (cnt_q == CNT_W'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              case (alu_op)
                ALU_MTHI: begin
                  hi_q   <= A;
                  done_q <= 1'b1;
                end
                ALU_MTLO: begin
                  lo_q   <= A;
                  done_q <= 1'b1;
                end
                ALU_MULT, ALU_MULTU: begin
                  prod_q    <= '0;
                  mcand_q   <= {{XLEN{1'b0}}, abs_a};
                  mplier_q  <= abs_b;
                  cnt_q     <= '0;
                  neg_res_q <= is_signed & (A[XLEN-1] ^ B[XLEN-1]);
                  neg_rem_q <= 1'b0;
                  is_div_q  <= 1'b0;
                  busy_q    <= 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
                  state_q   <= (abs_b == '0) ? ST_FIX : ST_MUL;
`else
                  state_q   <= ST_MUL;
`endif
                end
                ALU_DIV, ALU_DIVU: begin
                  if (B == '0) begin
                    hi_q   <= A;
                    lo_q   <= '1;
                    done_q <= 1'b1;
                    dbz_q  <= 1'b1;
                  end else begin
                    prod_q    <= {{XLEN{1'b0}}, abs_a};
                    mcand_q   <= {{XLEN{1'b0}}, abs_b};
                    cnt_q     <= '0;
                    neg_res_q <= is_signed & (A[XLEN-1] ^ B[XLEN-1]);
                    neg_rem_q <= is_signed & A[XLEN-1];
                    is_div_q  <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= ST_DIV;
                  end
                end
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            prod_q   <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_nxt;
            cnt_q    <= cnt_q + CNT_W'(1);
`ifdef MULDIV_EARLY_TERM_EN
            if (last_iter || (mplier_nxt == '0)) state_q <= ST_FIX;
`else
            if (last_iter) state_q <= ST_FIX;
`endif
          end
          ST_DIV: begin
            // Restoring step: keep the trial difference only when it did not go negative.
            prod_q <= {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                       prod_q[XLEN-2:0], ~div_diff[XLEN]};
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_iter) state_q <= ST_FIX;
          end
          ST_FIX: begin
            hi_q    <= is_div_q ? fix_rem : fix_prod[2*XLEN-1:XLEN];
            lo_q    <= fix_prod[XLEN-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_ix_muldiv_unit.sv
// tb/tb_ix_muldiv_unit.sv - self-checking bench for ix_muldiv_unit
module tb_ix_muldiv_unit;
  import ix_pkg::*;

`ifdef MULDIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  alu_op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int n_cmp = 0;
  int n_err = 0;

  ix_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          nbusy;
    int          ndone;
    int          ndbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; issues one op and observes a fixed 40-cycle window.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int ndone, output int ndbz);
    nbusy = 0; ndone = 0; ndbz = 0;
    start = 1'b1; alu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (div_by_zero) ndbz++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nd, nz;
    logic [31:0] keep_hi, keep_lo;

    vecs[0]  = '{ALU_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, ET ? 4 : 33, 1, 0};
    vecs[1]  = '{ALU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1, 0};
    vecs[2]  = '{ALU_DIVU,  32'hFFFFFFF9, 32'h2,        32'h1,        32'h7FFFFFFC, 33, 1, 0};
    vecs[3]  = '{ALU_DIVU,  32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF, 0,  1, 1};
    vecs[4]  = '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33, 1, 0};
    vecs[5]  = '{ALU_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        33, 1, 0};
    vecs[6]  = '{ALU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        ET ? 2 : 33, 1, 0};
    vecs[7]  = '{ALU_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 33, 1, 0};
    vecs[8]  = '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1, 0};
    vecs[9]  = '{ALU_MULT,  32'h5,        32'h0,        32'h0,        32'h0,        ET ? 1 : 33, 1, 0};
    vecs[10] = '{ALU_DIV,   32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 0,  1, 1};
    vecs[11] = '{6'h20,     32'h1,        32'h2,        32'h0,        32'hFFFFFFFF, 0,  0, 0};

    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_dbz", {31'b0, div_by_zero}, 32'h0);
    chk("reset_hi", hi_out, 32'h0);
    chk("reset_lo", lo_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, nb, nd, nz);
      chk($sformatf("vec%0d_hi", v), hi_out, vecs[v].hi);
      chk($sformatf("vec%0d_lo", v), lo_out, vecs[v].lo);
      chk($sformatf("vec%0d_busy_cycles", v), nb, vecs[v].nbusy);
      chk($sformatf("vec%0d_done_pulses", v), nd, vecs[v].ndone);
      chk($sformatf("vec%0d_dbz_pulses", v), nz, vecs[v].ndbz);
    end

    // Asynchronous reset in the middle of a division.
    run_op(ALU_MULT, 32'h3, 32'h5, nb, nd, nz);
    start = 1'b1; alu_op = ALU_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("middiv_busy_before_reset", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("middiv_reset_busy", {31'b0, busy}, 32'h0);
    chk("middiv_reset_done", {31'b0, done}, 32'h0);
    chk("middiv_reset_hi", hi_out, 32'h0);
    chk("middiv_reset_lo", lo_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(ALU_DIV, 32'd100, 32'd7, nb, nd, nz);
    chk("after_reset_div_hi", hi_out, 32'd2);
    chk("after_reset_div_lo", lo_out, 32'd14);
    chk("after_reset_div_done", nd, 32'd1);

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1; alu_op = ALU_MTHI; A = 32'hCAFEBABE;
    @(negedge clk);
    chk("mthi_hi", hi_out, 32'hCAFEBABE);
    chk("mthi_done", {31'b0, done}, 32'h1);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    alu_op = ALU_MTLO; A = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo_out, 32'h0BADF00D);
    chk("mtlo_hi_kept", hi_out, 32'hCAFEBABE);
    chk("mtlo_done", {31'b0, done}, 32'h1);
    chk("mtlo_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    chk("mt_done_drops", {31'b0, done}, 32'h0);

    // Flush at iteration 5 of a MULTU.
    keep_hi = 32'hCAFEBABE;
    keep_lo = 32'h0BADF00D;
    start = 1'b1; alu_op = ALU_MULTU; A = 32'h80000000; B = 32'h80000000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("flush_busy_before", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {31'b0, busy}, 32'h0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("flush_no_done", nd, 32'd0);
    chk("flush_hi_kept", hi_out, keep_hi);
    chk("flush_lo_kept", lo_out, keep_lo);
    run_op(ALU_MULTU, 32'h80000000, 32'h80000000, nb, nd, nz);
    chk("rerun_hi", hi_out, 32'h40000000);
    chk("rerun_lo", lo_out, 32'h0);

    // A start presented while a MULT is in flight must be ignored.
    start = 1'b1; alu_op = ALU_MULT; A = 32'hFFFFFFFD; B = 32'h7;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) begin
        start = 1'b1; alu_op = ALU_MTHI; A = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      if (done) nd++;
      @(negedge clk);
    end
    chk("busy_start_hi", hi_out, 32'hFFFFFFFF);
    chk("busy_start_lo", lo_out, 32'hFFFFFFEB);
    chk("busy_start_done", nd, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ix_muldiv_unit.md
Name: ix_muldiv_unit

Overview:
- Iterative multiply/divide unit on the IX stage. Consumes the ID/IX register outputs (alu_op, A, B) and computes MIPS MULT/MULTU/DIV/DIVU results into HI/LO.
- Asserts busy back to the hazard/stall logic so the ID/IX register holds while an operation is in flight.
- ID/IX outputs change on negedge clk; this block samples on posedge clk, so inputs are stable when sampled.

Parameters:
- XLEN, 32, operand/result width (HI and LO are each XLEN).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock, posedge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  ID/IX entry is a mul/div/MTHI/MTLO op, valid this cycle
- alu_op  input  6  operation code from ID/IX alu_op_out
- A  input  XLEN  source 1 (dividend / multiplicand / MTHI-MTLO data)
- B  input  XLEN  source 2 (divisor / multiplier)
- flush  input  1  abort the in-flight op (branch squash)
- busy  output  1  registered; high while state != IDLE
- done  output  1  one-cycle pulse when HI/LO are written
- div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with B==0
- hi_out  output  XLEN  HI register
- lo_out  output  XLEN  LO register

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0; counter and working registers cleared. Reset mid-operation abandons the op.
- Opcodes: MULT=6'h18, MULTU=6'h19, DIV=6'h1A, DIVU=6'h1B, MTHI=6'h11, MTLO=6'h13. start with any other code is ignored.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start:
  - MTHI/MTLO: write hi_out or lo_out with A at the same edge; done=1 next cycle; busy stays 0.
  - DIV/DIVU with B==0: hi_out=A, lo_out=all ones; done=1 and div_by_zero=1; no iteration.
  - MULT/DIV: capture |A| and |B|, record result signs, counter=0, go to MUL/DIV. MULTU/DIVU: operands are taken unsigned.
- MUL: shift-add, one multiplier bit per cycle, 2*XLEN product register. Exit to FIX after XLEN iterations (counter==XLEN-1).
- DIV: restoring division, one quotient bit per cycle. Exit to FIX after XLEN iterations.
- FIX, one cycle:
  - Apply two's-complement negation where needed, then write hi_out/lo_out; done=1 for the following cycle; next state IDLE.
  - MULT: product negated if sign(A) != sign(B). HI = upper product, LO = lower product.
  - DIV: quotient (LO) negated if signs differ; remainder (HI) takes the sign of the dividend. Truncation is toward zero.
  - -2^31 / -1 gives LO=0x80000000, HI=0.
- Latency, MULT/DIV: start sampled at edge 0, XLEN iteration edges, FIX at edge XLEN+1. HI/LO are visible and done is high after edge 33 (XLEN=32). busy is high from edge 0 until edge 33.
- start while busy: ignored. The stall guarantees it does not happen; the bench checks that it is ignored.
- flush: at the next edge, any state returns to IDLE. HI/LO are unchanged and done is not pulsed. flush has priority over start in the same cycle.
- done and div_by_zero are high for exactly one cycle.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- Defined: in MUL, if the remaining shifted multiplier is zero at the start of a cycle, go directly to FIX. Iterations = (MSB index of |B|)+1; |B|==0 gives 0 iterations. DIV latency is unchanged.
- Undefined: fixed XLEN iterations for all mul/div ops.

Decomposition:
- Shared package ix_pkg: opcode localparams (ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO), FSM state encoding, XLEN default.
- One natural sub-module: muldiv_negate, a combinational conditional two's-complement block. It is instantiated for operand magnitude capture and for FIX.

Test Plan:
- Reset asserted mid-DIV (counter ~10) -> immediately busy=0, done=0, hi_out=lo_out=0; later ops start cleanly.
- MULT A=0xFFFFFFFD (-3), B=7 -> after 33 cycles hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, single done pulse; busy high exactly 33 cycles. With MULDIV_EARLY_TERM_EN, busy=4 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). DIVU same operands -> lo_out=0x7FFFFFFC, hi_out=1.
- DIVU A=0x1234, B=0 -> next cycle done=1, div_by_zero=1, hi_out=0x1234, lo_out=0xFFFFFFFF; busy never high.
- MULTU A=0x80000000, B=0x80000000; flush at iteration 5 -> busy drops next edge, no done, HI/LO keep prior values. Rerun without flush -> hi_out=0x40000000, lo_out=0.
- MTHI A=0xCAFEBABE then MTLO A=0x0BADF00D back-to-back -> each updates in 1 cycle with a done pulse. A start presented while busy during a MULT is ignored.
